// File: rtl/psram_bus_bridge_pkg.sv
// Shared types and constants for the PSRAM request-side bridge.
//   - br_state_e : sequencer state encoding (2-bit)
//   - PsramBrBytes : bytes per word burst
//   - PsramBrTimeout : default XFER timeout in cycles
//   - align_word() : clears the byte-offset bits of an address
package psram_bus_bridge_pkg;

  typedef enum logic [1:0] {
    PsramBrIdle  = 2'd0,
    PsramBrIssue = 2'd1,
    PsramBrXfer  = 2'd2,
    PsramBrResp  = 2'd3
  } br_state_e;

  localparam int unsigned PsramBrBytes   = 4;
  localparam int unsigned PsramBrTimeout = 1024;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/psram_bus_bridge_word_buf.sv
// 4x8 byte buffer for one word burst.
//   clk_i, rst_n_i : clock, async active-low reset (contents clear to 0)
//   load_i/load_data_i : parallel load of a full little-endian word
//   wr_en_i/wr_ptr_i/wr_data_i : single byte write at a pointer
//   rd_ptr_i/rd_byte_o : combinational byte read
//   word_o : full 32-bit read-out, byte 0 in bits [7:0]
module psram_bus_bridge_word_buf (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        load_i,
  input  logic [31:0] load_data_i,
  input  logic        wr_en_i,
  input  logic [1:0]  wr_ptr_i,
  input  logic [7:0]  wr_data_i,
  input  logic [1:0]  rd_ptr_i,
  output logic [7:0]  rd_byte_o,
  output logic [31:0] word_o
);

  logic [3:0][7:0] bytes_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bytes_q <= '0;
    end else if (load_i) begin
      bytes_q <= load_data_i;
    end else if (wr_en_i) begin
      bytes_q[wr_ptr_i] <= wr_data_i;
    end
  end

  assign rd_byte_o = bytes_q[rd_ptr_i];
  assign word_o    = bytes_q;

endmodule

// File: rtl/psram_bus_bridge.sv
// Request-side sequencer in front of the PSRAM OPI core. Accepts one 32-bit
// word request, launches a 4-byte burst, feeds write bytes / packs read bytes,
// and returns a single response with an error flag.
//   clk_i, rst_n_i : clock, async active-low reset
//   en_i : gates acceptance of new requests only
//   req_* : request valid/ready channel (we, addr, wdata)
//   rsp_* : response valid/ready channel (rdata, err)
//   xfer_start_o/we_o/addr_o/abort_o : transaction control towards the core
//   wbyte_req_i/wbyte_o : write byte stream consumed by the core
//   rbyte_vld_i/rbyte_i : read byte stream produced by the core
//   xfer_done_i : core transaction complete pulse
module psram_bus_bridge
  import psram_bus_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = PsramBrTimeout,
  parameter int unsigned TO_WIDTH    = 11
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        en_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        xfer_start_o,
  output logic        xfer_we_o,
  output logic [31:0] xfer_addr_o,
  output logic        xfer_abort_o,
  input  logic        wbyte_req_i,
  output logic [7:0]  wbyte_o,
  input  logic        rbyte_vld_i,
  input  logic [7:0]  rbyte_i,
  input  logic        xfer_done_i
);

  localparam logic [2:0] PtrFull = 3'(PsramBrBytes);

  br_state_e           state_q, state_d;
  logic                we_q, we_d;
  logic [31:0]         addr_q, addr_d;
  logic [2:0]          wptr_q, wptr_d;
  logic [2:0]          rptr_q, rptr_d;
  logic [TO_WIDTH-1:0] cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                ready_q, ready_d;
  logic                start_q, start_d;
  logic                abort_q, abort_d;

  logic                accept;
  logic                buf_load;
  logic                buf_wr;
  logic [7:0]          buf_byte;
  logic [31:0]         buf_word;

  // Ready comes from a flop so it reads 0 while reset is asserted.
  assign req_ready_o = ready_q & en_i;
  assign accept      = req_valid_i & req_ready_o;

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    start_d  = 1'b0;
    abort_d  = 1'b0;
    buf_load = 1'b0;
    buf_wr   = 1'b0;

    unique case (state_q)
      PsramBrIdle: begin
        if (accept) begin
          we_d     = req_we_i;
          addr_d   = align_word(req_addr_i);
          wptr_d   = '0;
          rptr_d   = '0;
          cnt_d    = '0;
          err_d    = 1'b0;
          start_d  = 1'b1;
          buf_load = 1'b1;
          state_d  = PsramBrIssue;
        end
      end

      PsramBrIssue: begin
        state_d = PsramBrXfer;
      end

      PsramBrXfer: begin
        cnt_d = cnt_q + TO_WIDTH'(1);
        if (wbyte_req_i) begin
          if (wptr_q == PtrFull) err_d = 1'b1;
          else                   wptr_d = wptr_q + 3'd1;
        end
        if (rbyte_vld_i) begin
          if (rptr_q == PtrFull) begin
            err_d = 1'b1;
          end else begin
            buf_wr = 1'b1;
            rptr_d = rptr_q + 3'd1;
          end
        end
        // Byte count uses the updated pointers so a byte coincident with
        // done is counted.
        if (xfer_done_i) begin
          if ((we_q ? wptr_d : rptr_d) != PtrFull) err_d = 1'b1;
          state_d = PsramBrResp;
        end else if (cnt_q == TO_WIDTH'(TIMEOUT_CYC - 1)) begin
          abort_d = 1'b1;
          err_d   = 1'b1;
          state_d = PsramBrResp;
        end
      end

      PsramBrResp: begin
        if (rsp_ready_i) state_d = PsramBrIdle;
      end

      default: state_d = PsramBrIdle;
    endcase
  end

  assign ready_d = (state_d == PsramBrIdle);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= PsramBrIdle;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      start_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      start_q <= start_d;
      abort_q <= abort_d;
    end
  end

  psram_bus_bridge_word_buf u_word_buf (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .load_i      (buf_load),
    .load_data_i (req_wdata_i),
    .wr_en_i     (buf_wr),
    .wr_ptr_i    (rptr_q[1:0]),
    .wr_data_i   (rbyte_i),
    .rd_ptr_i    (wptr_q[1:0]),
    .rd_byte_o   (buf_byte),
    .word_o      (buf_word)
  );

  assign rsp_valid_o  = (state_q == PsramBrResp);
  assign rsp_rdata_o  = (rsp_valid_o && !we_q) ? buf_word : 32'h0;
  assign rsp_err_o    = rsp_valid_o & err_q;
  assign xfer_start_o = start_q;
  assign xfer_abort_o = abort_q;
  assign xfer_we_o    = we_q;
  assign xfer_addr_o  = addr_q;
  // Past the fourth byte the core gets zeros.
  assign wbyte_o      = ((state_q == PsramBrXfer) && (wptr_q != PtrFull)) ? buf_byte : 8'h00;

endmodule

// File: tb/tb_psram_bus_bridge.sv
module tb_psram_bus_bridge;

  localparam int TO = 16;

  logic        clk;
  logic        rst_n;
  logic        en_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        xfer_start_o;
  logic        xfer_we_o;
  logic [31:0] xfer_addr_o;
  logic        xfer_abort_o;
  logic        wbyte_req_i;
  logic [7:0]  wbyte_o;
  logic        rbyte_vld_i;
  logic [7:0]  rbyte_i;
  logic        xfer_done_i;

  int n_pass  = 0;
  int n_total = 0;

  int         btime[8];
  logic [7:0] rb[8];

  psram_bus_bridge #(
    .TIMEOUT_CYC (TO),
    .TO_WIDTH    (5)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .en_i         (en_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_rdata_o  (rsp_rdata_o),
    .rsp_err_o    (rsp_err_o),
    .xfer_start_o (xfer_start_o),
    .xfer_we_o    (xfer_we_o),
    .xfer_addr_o  (xfer_addr_o),
    .xfer_abort_o (xfer_abort_o),
    .wbyte_req_i  (wbyte_req_i),
    .wbyte_o      (wbyte_o),
    .rbyte_vld_i  (rbyte_vld_i),
    .rbyte_i      (rbyte_i),
    .xfer_done_i  (xfer_done_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [79:0] all_outs();
    return {req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, xfer_start_o, xfer_we_o,
            xfer_addr_o, xfer_abort_o, wbyte_o};
  endfunction

  // Byte schedule: byte i is offered in XFER cycle btime[i]. Returns last time.
  function automatic int plan(input int n, input bit gaps);
    int t = 0;
    for (int i = 0; i < n; i++) begin
      btime[i] = t;
      rb[i]    = 8'($urandom);
      t += 1 + (gaps ? int'($urandom_range(0, 1)) : 0);
    end
    return btime[n-1];
  endfunction

  // One request end to end. td < 0: core never signals done.
  // Entered and left at 1 time unit after a rising edge.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input int n, input int td, input int rsp_delay);
    bit          tmo;
    bit          exp_err;
    logic [31:0] exp_rd;
    logic [7:0]  eb;
    bit          rdy;
    bit          fire;
    int          bi;
    int          wk;

    // Reference: what the bus should see, from the request and byte stream.
    tmo    = (td < 0) || (td > TO - 1);
    exp_rd = wdata;
    for (int i = 0; i < n && i < 4; i++)
      exp_rd = (exp_rd & ~(32'hFF << (8 * i))) | (32'(rb[i]) << (8 * i));
    if (we) exp_rd = 32'h0;
    exp_err = tmo || (n != 4);

    en_i        = 1'b1;
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    rdy = 1'b0;
    for (int w = 0; w < 20; w++) begin
      #4;
      if (req_ready_o) begin
        rdy = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("req_accepted", 80'(rdy), 80'd1);
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    if (!rdy) return;

    // Enable may drop mid-transaction without effect on it.
    en_i = 1'($urandom_range(0, 1));
    #4;
    chk("xfer_start", 80'(xfer_start_o), 80'd1);
    chk("xfer_addr", 80'(xfer_addr_o), 80'(addr & 32'hFFFF_FFFC));
    chk("xfer_we", 80'(xfer_we_o), 80'(we));
    @(posedge clk); #1;

    bi = 0;
    wk = 0;
    for (int t = 0; t < TO; t++) begin
      fire        = (bi < n) && (t == btime[bi]);
      wbyte_req_i = fire && we;
      rbyte_vld_i = fire && !we;
      rbyte_i     = fire ? rb[bi] : 8'h00;
      xfer_done_i = (t == td);
      #4;
      if (t == 0) chk("start_single", 80'(xfer_start_o), 80'd0);
      if (wbyte_req_i) begin
        eb = (wk < 4) ? 8'((wdata >> (8 * wk)) & 32'hFF) : 8'h00;
        chk("wbyte", 80'(wbyte_o), 80'(eb));
        wk++;
      end
      chk("xfer_quiet", 80'({xfer_abort_o, rsp_valid_o}), 80'd0);
      if (fire) bi++;
      @(posedge clk); #1;
      if (xfer_done_i) break;
    end
    wbyte_req_i = 1'b0;
    rbyte_vld_i = 1'b0;
    rbyte_i     = 8'h00;
    xfer_done_i = 1'b0;

    #4;
    chk("rsp_valid", 80'(rsp_valid_o), 80'd1);
    chk("abort", 80'(xfer_abort_o), 80'(tmo));
    chk("rsp_err", 80'(rsp_err_o), 80'(exp_err));
    chk("rsp_rdata", 80'(rsp_rdata_o), 80'(exp_rd));

    for (int d = 0; d < rsp_delay; d++) begin
      @(posedge clk); #4;
      if (d == 0) chk("abort_one_cycle", 80'(xfer_abort_o), 80'd0);
    end
    if (rsp_delay > 0) begin
      chk("hold_rsp", 80'({rsp_valid_o, rsp_err_o, rsp_rdata_o}),
          80'({1'b1, exp_err, exp_rd}));
      chk("hold_ready_low", 80'(req_ready_o), 80'd0);
    end
    rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    rsp_ready_i = 1'b0;
    #4;
    chk("rsp_retired", 80'(rsp_valid_o), 80'd0);
    chk("ready_back", 80'(req_ready_o), 80'(en_i));
    @(posedge clk); #1;
    en_i = 1'b1;
  endtask

  initial begin
    int last;
    int r;
    int n;
    int td;
    logic we;

    rst_n       = 1'b0;
    en_i        = 1'b1;
    req_valid_i = 1'b0;
    req_we_i    = 1'b0;
    req_addr_i  = '0;
    req_wdata_i = '0;
    rsp_ready_i = 1'b0;
    wbyte_req_i = 1'b0;
    rbyte_vld_i = 1'b0;
    rbyte_i     = '0;
    xfer_done_i = 1'b0;

    #3;
    chk("reset_outputs", all_outs(), 80'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed write: AA BB CC DD, done one cycle after the last byte.
    last = plan(4, 1'b0);
    txn(1'b1, 32'h0000_1003, 32'hDDCC_BBAA, 4, last + 1, 0);

    // Directed read: last byte coincident with done.
    last = plan(4, 1'b0);
    rb[0] = 8'h11; rb[1] = 8'h22; rb[2] = 8'h33; rb[3] = 8'h44;
    txn(1'b0, 32'h0000_2000, 32'h0, 4, last, 0);

    // Timeout: no done at all.
    last = plan(4, 1'b0);
    txn(1'b0, 32'h0000_3004, 32'h5555_AAAA, 4, -1, 0);

    // Done in the final XFER cycle beats the timeout.
    last = plan(4, 1'b0);
    txn(1'b1, 32'h0000_4008, 32'h1234_5678, 4, TO - 1, 0);

    // Short read and overlong write.
    last = plan(3, 1'b0);
    txn(1'b0, 32'h0000_5000, 32'hCAFE_F00D, 3, last + 1, 0);
    last = plan(5, 1'b0);
    txn(1'b1, 32'h0000_6000, 32'h0BAD_BEEF, 5, last + 1, 0);

    // Response backpressure for ten cycles.
    last = plan(4, 1'b1);
    txn(1'b0, 32'h0000_7000, 32'h0, 4, last, 10);

    // Enable low blocks acceptance.
    en_i = 1'b0;
    req_valid_i = 1'b1;
    req_we_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #4;
      chk("en_low_ready", 80'({req_ready_o, xfer_start_o}), 80'd0);
      @(posedge clk); #1;
    end
    req_valid_i = 1'b0;
    en_i = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of XFER.
    req_valid_i = 1'b1;
    req_we_i    = 1'b1;
    req_addr_i  = 32'h0000_8000;
    req_wdata_i = 32'hA5A5_5A5A;
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    @(posedge clk); #1;
    #4;
    chk("in_xfer_wbyte", 80'(wbyte_o), 80'h5A);
    rst_n = 1'b0;
    #1;
    chk("midxfer_reset_outputs", all_outs(), 80'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    #4;
    chk("ready_after_reset", 80'({req_ready_o, rsp_valid_o}), 80'b10);
    @(posedge clk); #1;

    // Randomised traffic.
    for (int k = 0; k < 40; k++) begin
      we = 1'($urandom_range(0, 1));
      r  = int'($urandom_range(0, 3));
      n  = (r == 0) ? 3 : (r == 1) ? 5 : 4;
      last = plan(n, 1'b1);
      r  = int'($urandom_range(0, 7));
      if (r == 0)      td = -1;
      else if (r == 1) td = TO - 1;
      else if (we)     td = last + 1 + int'($urandom_range(0, 1));
      else             td = last + int'($urandom_range(0, 1));
      txn(we, $urandom, $urandom, n, td, int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
